// File: rtl/cu_fsm_if.sv
// cu_fsm_if: decoder/CSR/memory-facing signal bundle for the OTTER multi-cycle sequencer.
// slave  = sequencer side (cu_fsm), master = surrounding core / testbench side.
`timescale 1ns/1ps
interface cu_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic [2:0]           func;
  logic                 intrpt;
  logic                 mie;
  logic                 mem_ready;
  logic                 pc_reset;
  logic                 pc_write;
  logic                 rfile_write;
  logic                 mem_rden1;
  logic                 mem_rden2;
  logic                 mem_we2;
  logic                 csr_write;
  logic                 intrpt_taken;
  logic [CNT_WIDTH-1:0] instr_retired;

  modport slave (
    input  opcode, func, intrpt, mie, mem_ready,
    output pc_reset, pc_write, rfile_write, mem_rden1, mem_rden2, mem_we2,
           csr_write, intrpt_taken, instr_retired
  );

  modport master (
    output opcode, func, intrpt, mie, mem_ready,
    input  pc_reset, pc_write, rfile_write, mem_rden1, mem_rden2, mem_we2,
           csr_write, intrpt_taken, instr_retired
  );
endinterface

// File: rtl/cu_fsm.sv
// cu_fsm: OTTER RV32I multi-cycle sequencer (INIT/FETCH/EXEC/WB/INTRPT).
// Synchronises and latches the external interrupt, enters INTRPT only between
// instructions, and counts retired instructions.
// Optional feature macro: CU_FSM_MEM_STALL_EN -- FETCH and WB wait for mem_ready.
`timescale 1ns/1ps
module cu_fsm #(
  parameter int INTRPT_SYNC_STAGES = 2,
  parameter int CNT_WIDTH          = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  cu_fsm_if.slave  bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTRPT
  } state_t;

  state_t                        state_q, state_d;
  logic [INTRPT_SYNC_STAGES-1:0] sync_q;
  logic                          pending_q, pending_d;
  logic [CNT_WIDTH-1:0]          cnt_q;

  logic intr_s, take_int, mem_ok;
  logic pc_reset, pc_write, rfile_write, rden1, rden2, we2, csr_write, int_taken;

  assign intr_s   = sync_q[INTRPT_SYNC_STAGES-1];
  // Only sampled when leaving EXEC/WB, so an interrupt never splits an instruction.
  assign take_int = pending_q & bus.mie;

`ifdef CU_FSM_MEM_STALL_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Interrupt synchroniser chain (async level input).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[INTRPT_SYNC_STAGES-2:0], bus.intrpt};
  end

  // Pending latch: the INTRPT state clears it, overriding a simultaneous set.
  always_comb begin
    pending_d = pending_q | (intr_s & bus.mie);
    if (state_q == ST_INTRPT) pending_d = 1'b0;
  end

  // State and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d     = state_q;
    pc_reset    = 1'b0;
    pc_write    = 1'b0;
    rfile_write = 1'b0;
    rden1       = 1'b0;
    rden2       = 1'b0;
    we2         = 1'b0;
    csr_write   = 1'b0;
    int_taken   = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_reset = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        rden1 = 1'b1;
        if (mem_ok) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.opcode == OPC_LOAD) begin
          rden2   = 1'b1;
          state_d = ST_WB;
        end else begin
          pc_write = 1'b1;
          state_d  = take_int ? ST_INTRPT : ST_FETCH;
          case (bus.opcode)
            OPC_STORE:  we2 = 1'b1;
            OPC_SYSTEM: begin
              if (bus.func == 3'b001) begin
                csr_write   = 1'b1;
                rfile_write = 1'b1;
              end
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
              rfile_write = 1'b1;
            default: ;
          endcase
        end
      end
      ST_WB: begin
        // Writes are held off until the data port reports completion.
        if (mem_ok) begin
          rfile_write = 1'b1;
          pc_write    = 1'b1;
          state_d     = take_int ? ST_INTRPT : ST_FETCH;
        end
      end
      ST_INTRPT: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Retired-instruction counter: PC loads in EXEC/WB only; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (pc_write && !int_taken) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.pc_reset      = pc_reset;
  assign bus.pc_write      = pc_write;
  assign bus.rfile_write   = rfile_write;
  assign bus.mem_rden1     = rden1;
  assign bus.mem_rden2     = rden2;
  assign bus.mem_we2       = we2;
  assign bus.csr_write     = csr_write;
  assign bus.intrpt_taken  = int_taken;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: randomized self-checking bench for cu_fsm with an instruction-level
// reference model (strobe table per opcode, interrupt latency, modular count).
`timescale 1ns/1ps
module tb_cu_fsm;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cu_fsm_if #(.CNT_WIDTH(CW)) bus();
  cu_fsm #(.INTRPT_SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int obs_int = 0;

  // Reference model state.
  bit m_s0, m_s1, m_pend;
  int m_cnt;

  logic [6:0] ops [0:10];

  // Strobe bit order: pc_reset pc_write rfile_write rden1 rden2 we2 csr_write intrpt_taken
  localparam logic [7:0] E_INIT  = 8'b1000_0000;
  localparam logic [7:0] E_FETCH = 8'b0001_0000;
  localparam logic [7:0] E_WB    = 8'b0110_0000;
  localparam logic [7:0] E_INT   = 8'b0100_0001;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {bus.pc_reset, bus.pc_write, bus.rfile_write, bus.mem_rden1,
            bus.mem_rden2, bus.mem_we2, bus.csr_write, bus.intrpt_taken};
  endfunction

  function automatic logic [7:0] exp_exec(logic [6:0] op, logic [2:0] fn);
    case (op)
      7'b0000011: return 8'b0000_1000;                 // load
      7'b0100011: return 8'b0100_0100;                 // store
      7'b1110011: return (fn == 3'b001) ? 8'b0110_0010 : 8'b0100_0000;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
        return 8'b0110_0000;
      default:    return 8'b0100_0000;                 // branch, mret, unknown
    endcase
  endfunction

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_pend = 0; m_cnt = 0;
  endtask

  // One clock: update the interrupt model from pre-edge inputs, then step past the edge.
  task automatic tick(bit in_int);
    bit i, m;
    i = bus.intrpt;
    m = bus.mie;
    m_pend = in_int ? 1'b0 : (m_pend | (m_s1 & m));
    m_s1 = m_s0;
    m_s0 = i;
    @(posedge clk);
    #1;
  endtask

  // Exit of EXEC/WB: retire, then optional INTRPT (bench acts as CSR file clearing MIE).
  task automatic retire_exit();
    bit take;
    take = m_pend & bus.mie;
    m_cnt = (m_cnt + 1) % (1 << CW);
    tick(0);
    chk("cnt", 32'(bus.instr_retired), 32'(m_cnt));
    if (bus.intrpt_taken) obs_int++;
    chk("int_entry", 32'(bus.intrpt_taken), 32'(take));
    if (take) begin
      chk("intrpt", 32'(obs()), 32'(E_INT));
      bus.mie = 1'b0;
      tick(1);
      chk("cnt_after_int", 32'(bus.instr_retired), 32'(m_cnt));
    end
  endtask

  // Starts in FETCH, ends in the next FETCH.
  task automatic do_instr(logic [6:0] op, logic [2:0] fn);
    bus.opcode = op;
    bus.func   = fn;
    chk("fetch", 32'(obs()), 32'(E_FETCH));
    tick(0);
    chk("exec", 32'(obs()), 32'(exp_exec(op, fn)));
    if (op == 7'b0000011) begin
      tick(0);
      chk("wb", 32'(obs()), 32'(E_WB));
    end
    retire_exit();
  endtask

  initial begin
    int base;
    logic [6:0] op;
    logic [2:0] fn;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111};
    rst_n = 1'b0;
    bus.opcode = '0; bus.func = '0; bus.intrpt = 0; bus.mie = 0; bus.mem_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 32'(obs()), 32'(E_INIT));
    chk("rst_cnt", 32'(bus.instr_retired), 0);
    rst_n = 1'b1;
    chk("init", 32'(obs()), 32'(E_INIT));
    tick(0);

    // OP-IMM then LOAD.
    do_instr(7'b0010011, 3'b000);
    chk("first_cnt", 32'(bus.instr_retired), 1);
    do_instr(7'b0000011, 3'b010);
    chk("load_cnt", 32'(bus.instr_retired), 2);

    // Interrupt raised at the start of a STORE: taken after a following instruction.
    base = obs_int;
    bus.intrpt = 1; bus.mie = 1;
    do_instr(7'b0100011, 3'b010);
    do_instr(7'b0110011, 3'b000);
    chk("int_store_seq", 32'(obs_int - base), 1);

    // Request held with MIE clear: no entry for 20 instructions, then raise MIE.
    bus.mie = 0;
    base = obs_int;
    for (int k = 0; k < 20; k++) do_instr(ops[$urandom_range(0, 10)], 3'b000);
    chk("no_int_mie0", 32'(obs_int - base), 0);
    bus.mie = 1;
    do_instr(7'b0010011, 3'b000);
    chk("int_after_mie", 32'(obs_int - base), 1);
    bus.intrpt = 0;

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) bus.intrpt = ~bus.intrpt;
      if ($urandom_range(0, 3) == 0) bus.mie = 1'($urandom_range(0, 1));
      op = ops[$urandom_range(0, 10)];
      fn = (op == 7'b1110011) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      do_instr(op, fn);
    end

    // Counter wrap at all-ones.
    bus.intrpt = 0; bus.mie = 0;
    for (int k = 0; k < 20 && m_cnt != (1 << CW) - 1; k++) do_instr(7'b0110011, 3'b000);
    chk("cnt_all_ones", 32'(bus.instr_retired), 32'((1 << CW) - 1));
    do_instr(7'b0110011, 3'b000);
    chk("wrap", 32'(bus.instr_retired), 0);

`ifdef CU_FSM_MEM_STALL_EN
    // FETCH stalled 3 cycles, then WB stalled 2 cycles.
    bus.opcode = 7'b0000011; bus.func = 3'b010;
    bus.mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_fetch", 32'(obs()), 32'(E_FETCH));
      tick(0);
    end
    bus.mem_ready = 1;
    chk("stall_fetch_last", 32'(obs()), 32'(E_FETCH));
    tick(0);
    chk("stall_exec", 32'(obs()), 32'(exp_exec(7'b0000011, 3'b010)));
    tick(0);
    bus.mem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      chk("stall_wb", 32'(obs()), 0);
      chk("stall_wb_cnt", 32'(bus.instr_retired), 32'(m_cnt));
      tick(0);
    end
    bus.mem_ready = 1;
    chk("stall_wb_go", 32'(obs()), 32'(E_WB));
    retire_exit();
`endif

    // Reset pulsed in the middle of WB.
    bus.opcode = 7'b0000011;
    chk("pre_rst_fetch", 32'(obs()), 32'(E_FETCH));
    tick(0);
    tick(0);
    chk("pre_rst_wb", 32'(obs()), 32'(E_WB));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wb", 32'(obs()), 32'(E_INIT));
    chk("rst_mid_cnt", 32'(bus.instr_retired), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reinit", 32'(obs()), 32'(E_INIT));
    tick(0);
    do_instr(7'b0110111, 3'b000);
    chk("post_rst_cnt", 32'(bus.instr_retired), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
